// File: rtl/isa_pkg.sv
// isa_pkg: instruction-word geometry, reserved words and fetch FSM states shared by the fetch stage.
package isa_pkg;
  localparam int ISA_INSTR_W = 9;
  localparam int ISA_PC_W = 16;
  localparam int ISA_DEPTH = 128;
  localparam int ISA_NUM_PROGS = 4;
  localparam logic [8:0] NOP_WORD = 9'h000;
  localparam logic [8:0] ISA_HALT_WORD = 9'h1B0;
  localparam int FMT_BIT = 8;
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int SIGN_BIT = 3;
  localparam int OPR_MSB = 2;
  localparam int IMM_MSB = 7;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_HALT = 4'hB;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_e;
endpackage

// File: rtl/imem_bank.sv
// imem_bank: program store with synchronous write and registered read; only the read register resets.
module imem_bank #(
  parameter int W = 9,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: loadable multi-bank instruction memory with registered fetch, run control and field decode.
module instr_fetch_mem
  import isa_pkg::*;
#(
  parameter int INSTR_W = ISA_INSTR_W,
  parameter int PC_W = ISA_PC_W,
  parameter int DEPTH = ISA_DEPTH,
  parameter int NUM_PROGS = ISA_NUM_PROGS,
  parameter logic [INSTR_W-1:0] HALT_WORD = ISA_HALT_WORD
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [$clog2(NUM_PROGS)-1:0] prog_sel,
  input  logic                         load_en,
  input  logic [$clog2(NUM_PROGS)-1:0] load_bank,
  input  logic [$clog2(DEPTH)-1:0]     load_addr,
  input  logic [INSTR_W-1:0]           load_data,
  output logic                         load_err,
  input  logic                         fetch_req,
  input  logic [PC_W-1:0]              pc_in,
  input  logic                         stall,
  output logic                         instr_valid,
  output logic                         out_of_range,
  output logic                         halted,
  output logic                         format,
  output logic [3:0]                   opcode,
  output logic                         sign,
  output logic [2:0]                   operand,
  output logic [7:0]                   immediate
);
  localparam int BW = $clog2(NUM_PROGS);
  localparam int AW = $clog2(DEPTH);
  state_e state;
  logic [BW-1:0] bank;
  logic valid_q, oor_q, load_err_q;
  logic [INSTR_W-1:0] rdata, word;
  logic go, halt_now, accept, in_range;
  assign go = start & (state != S_RUN);
  assign in_range = pc_in < PC_W'(DEPTH);
  // An out-of-range fetch skips the RAM read, so its NOP is produced by masking the stale read data.
  assign word = oor_q ? NOP_WORD : rdata;
  assign halt_now = (state == S_RUN) & valid_q & (word == HALT_WORD);
  assign accept = (state == S_RUN) & fetch_req & ~stall & ~halt_now;
  imem_bank #(.W(INSTR_W), .AW(BW + AW)) u_bank (
    .clk  (clk),
    .rst_n(reset_n),
    .we   (load_en & (state != S_RUN)),
    .waddr({load_bank, load_addr}),
    .wdata(load_data),
    .re   (accept & in_range),
    .raddr({bank, pc_in[AW-1:0]}),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      bank <= '0;
      valid_q <= 1'b0;
      oor_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_en & (state == S_RUN);
      if (go) begin
        state <= S_RUN;
        bank <= prog_sel;
      end else if (halt_now) state <= S_HALTED;
      valid_q <= go ? 1'b0 : stall ? valid_q : accept;
      if (accept) oor_q <= ~in_range;
    end
  assign load_err = load_err_q;
  assign instr_valid = valid_q;
  assign out_of_range = valid_q & oor_q;
  assign halted = (state == S_HALTED) | halt_now;
  assign format = word[FMT_BIT];
  assign opcode = word[OPC_MSB:OPC_LSB];
  assign sign = word[SIGN_BIT];
  assign operand = word[OPR_MSB:0];
  assign immediate = word[IMM_MSB:0];
endmodule
